// File: rtl/frame_seq_ctrl_pkg.sv
// Shared definitions for the frame sequencer: one-hot phase encoding and default
// frame geometry, also used by the filter-core top and the bench.
package frame_seq_ctrl_pkg;

    localparam int unsigned DEF_IMG_W    = 1026;
    localparam int unsigned DEF_IMG_H    = 1024;
    localparam int unsigned DEF_PIPE_LAT = 5149;
    localparam int unsigned DEF_CW       = 21;

    typedef enum logic [4:0] {
        ST_IDLE  = 5'b00001,
        ST_FILL  = 5'b00010,
        ST_RUN   = 5'b00100,
        ST_FLUSH = 5'b01000,
        ST_DONE  = 5'b10000
    } state_t;

    function automatic int unsigned frame_pix(input int unsigned w, input int unsigned h);
        return w * h;
    endfunction

endpackage

// File: rtl/frame_seq_ctrl_beat_cnt.sv
// Beat counter: clears on clr, counts on inc, flags equality with a match value.
module beat_cnt #(
    parameter int unsigned CW = 21
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          inc,
    input  logic [CW-1:0] match,
    output logic          eq
);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign eq = (cnt == match);

endmodule

// File: rtl/frame_seq_ctrl.sv
// Frame sequencer around the streaming 2-D filter datapath (fill/run/flush gating, m_last).
// Optional s_last framing check enabled by defining FRAME_SEQ_LAST_CHK_EN.
module frame_seq_ctrl
    import frame_seq_ctrl_pkg::*;
#(
    parameter int unsigned IMG_W    = DEF_IMG_W,
    parameter int unsigned IMG_H    = DEF_IMG_H,
    parameter int unsigned PIPE_LAT = DEF_PIPE_LAT,
    parameter int unsigned CW       = DEF_CW
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic       s_last,
    output logic       dp_in_valid,
    input  logic       dp_in_ready,
    output logic       flush_en,
    input  logic       dp_out_valid,
    output logic       dp_out_ready,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       m_last,
    output logic [4:0] state,
    output logic       busy,
    output logic       done,
    output logic       err_last
);

    localparam int unsigned   FRAME_PIX = frame_pix(IMG_W, IMG_H);
    localparam logic [CW-1:0] FILL_LAST = CW'(PIPE_LAT - 1);
    localparam logic [CW-1:0] PIX_LAST  = CW'(FRAME_PIX - 1);
    localparam logic [CW-1:0] FLUSH_LEN = CW'(PIPE_LAT);

    state_t        st, st_nx;
    logic          in_phase, out_en;
    logic          in_hs, out_hs, fl_hs, start_acc;
    logic          in_eq, out_eq, fl_eq;
    logic [CW-1:0] in_match;

    assign in_hs     = s_valid & s_ready;
    assign out_hs    = m_valid & m_ready;
    assign fl_hs     = flush_en & dp_in_ready;
    assign start_acc = start & (st == ST_IDLE);

    // The input counter serves both the fill boundary and the end-of-frame beat.
    assign in_match = (st == ST_FILL) ? FILL_LAST : PIX_LAST;

    beat_cnt #(.CW(CW)) u_in_cnt (
        .clk(clk), .rst_n(rst_n), .clr(start_acc), .inc(in_hs), .match(in_match), .eq(in_eq)
    );

    beat_cnt #(.CW(CW)) u_out_cnt (
        .clk(clk), .rst_n(rst_n), .clr(start_acc), .inc(out_hs), .match(PIX_LAST), .eq(out_eq)
    );

    beat_cnt #(.CW(CW)) u_fl_cnt (
        .clk(clk), .rst_n(rst_n), .clr(start_acc), .inc(fl_hs), .match(FLUSH_LEN), .eq(fl_eq)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st <= ST_IDLE;
        end else begin
            st <= st_nx;
        end
    end

    always_comb begin
        st_nx = st;
        unique case (st)
            ST_IDLE:  if (start)                st_nx = ST_FILL;
            ST_FILL:  if (in_hs && in_eq)       st_nx = ST_RUN;
            ST_RUN:   if (in_hs && in_eq)       st_nx = ST_FLUSH;
            ST_FLUSH: if (out_hs && out_eq)     st_nx = ST_DONE;
            ST_DONE:                            st_nx = ST_IDLE;
            default:                            st_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        in_phase     = (st == ST_FILL) || (st == ST_RUN);
        out_en       = (st == ST_RUN) || (st == ST_FLUSH);
        s_ready      = dp_in_ready & in_phase;
        dp_in_valid  = s_valid & in_phase;
        flush_en     = (st == ST_FLUSH) & ~fl_eq;
        dp_out_ready = out_en ? m_ready : 1'b1;
        m_valid      = dp_out_valid & out_en;
        m_last       = out_en & out_eq;
        busy         = (st != ST_IDLE);
        done         = (st == ST_DONE);
        state        = st;
    end

`ifdef FRAME_SEQ_LAST_CHK_EN
    logic err_q;
    logic exp_last;

    // in_eq only marks the final pixel outside FILL.
    assign exp_last = in_eq & (st != ST_FILL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (start_acc) begin
            err_q <= 1'b0;
        end else if (in_hs && (s_last != exp_last)) begin
            err_q <= 1'b1;
        end
    end

    assign err_last = err_q;
`else
    logic s_last_unused;
    assign s_last_unused = s_last;
    assign err_last      = 1'b0;
`endif

endmodule

// File: tb/tb_frame_seq_ctrl.sv
// Scoreboard bench for frame_seq_ctrl with a behavioural source, datapath and sink model.
module tb_frame_seq_ctrl;
    import frame_seq_ctrl_pkg::*;

    localparam int unsigned W = 4, H = 3, PL = 5;
    localparam int NPIX = 12;
`ifdef FRAME_SEQ_LAST_CHK_EN
    localparam bit LCHK = 1'b1;
`else
    localparam bit LCHK = 1'b0;
`endif

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic s_valid = 1'b0, s_last = 1'b0, dp_in_ready = 1'b0, dp_out_valid = 1'b0, m_ready = 1'b0;
    logic s_ready, dp_in_valid, flush_en, dp_out_ready, m_valid, m_last, busy, done, err_last;
    logic [4:0] state;

    frame_seq_ctrl #(.IMG_W(W), .IMG_H(H), .PIPE_LAT(PL), .CW(21)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .s_valid(s_valid), .s_ready(s_ready),
        .s_last(s_last), .dp_in_valid(dp_in_valid), .dp_in_ready(dp_in_ready),
        .flush_en(flush_en), .dp_out_valid(dp_out_valid), .dp_out_ready(dp_out_ready),
        .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last), .state(state),
        .busy(busy), .done(done), .err_last(err_last)
    );

    always #5 clk = ~clk;

    typedef struct { int val; bit last; } exp_t;
    exp_t exp_q[$];
    int   dp_q[$];
    int   dp_out_data = 0;

    int checks = 0, errors = 0;
    int unsigned sv_pct = 100, mr_pct = 100, dr_pct = 100;
    int  last_pos = NPIX;
    int  src_idx = 1, src_acc = 0, fl_beats = 0, dp_beats = 0, done_cnt = 0;
    bit  src_on = 1'b0, dr_hold_low = 1'b0, err_exp = 1'b0;
    bit  hs_in = 1'b0, prev_stall = 1'b0;
    int  prev_data = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: handshakes seen here complete on the following rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            bit h_dp, h_fl, h_out, h_dpo;
            exp_t e;
            hs_in = s_valid & s_ready;
            h_dp  = (dp_in_valid | flush_en) & dp_in_ready;
            h_fl  = flush_en & dp_in_ready;
            h_out = m_valid & m_ready;
            h_dpo = dp_out_valid & dp_out_ready;

            chk("err_last", err_last, err_exp);
            if (prev_stall) begin
                chk("m_valid_hold", m_valid, 1);
                chk("m_data_hold", dp_out_data, prev_data);
            end
            if (m_valid && exp_q.size() > 0) chk("m_last_level", m_last, exp_q[0].last);
            if (h_out) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", dp_out_data, e.val);
                    chk("out_last", m_last, e.last);
                end
            end
            prev_stall = m_valid & ~m_ready;
            prev_data  = dp_out_data;
            if (done) done_cnt++;

            if (hs_in) begin
                if (LCHK && ((src_idx == last_pos) != (src_idx == NPIX))) err_exp = 1'b1;
                src_acc++;
                src_idx++;
                if (src_acc > NPIX) chk("input_overrun", src_acc, NPIX);
            end
            if (start && state == ST_IDLE) err_exp = 1'b0;
            if (h_fl) fl_beats++;
            if (h_dpo && dp_q.size() > 0) void'(dp_q.pop_front());
            // Datapath model: warm-up junk for the first PL-1 beats, none for beat PL,
            // then window k for beat PL+k.
            if (h_dp) begin
                dp_beats++;
                if (dp_beats < PL) dp_q.push_back(0);
                else if (dp_beats > PL) dp_q.push_back(dp_beats - PL);
            end
        end
    end

    task automatic drive();
        dp_out_valid = (dp_q.size() > 0);
        dp_out_data  = (dp_q.size() > 0) ? dp_q[0] : 0;
        dp_in_ready  = !dr_hold_low && (dp_q.size() < 4) && ($urandom_range(99) < dr_pct);
        m_ready      = ($urandom_range(99) < mr_pct);
        if (!(s_valid && !hs_in))
            s_valid = src_on && (src_idx <= NPIX) && ($urandom_range(99) < sv_pct);
        s_last = s_valid && (src_idx == last_pos);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic begin_frame(input int unsigned sv, input int unsigned mr, input int unsigned dr,
                               input int lp);
        sv_pct = sv; mr_pct = mr; dr_pct = dr; last_pos = lp;
        src_idx = 1; src_acc = 0; fl_beats = 0; dp_beats = 0; done_cnt = 0;
        exp_q.delete();
        for (int k = 1; k <= NPIX; k++) exp_q.push_back('{k, (k == NPIX)});
        src_on = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_to_fill", state, ST_FILL);
        chk("busy_after_start", busy, 1);
    endtask

    task automatic run_frame(input int unsigned sv, input int unsigned mr, input int unsigned dr,
                             input int lp, input bit pulse_in_run, input bit hold_fl);
        int  cyc = 0, fb;
        bit  seen_run = 0, seen_flush = 0, pulsed = 0, held = 0;
        begin_frame(sv, mr, dr, lp);
        while (state != ST_IDLE && cyc < 3000) begin
            if (state == ST_RUN && !seen_run) begin
                seen_run = 1;
                chk("fill_beats", src_acc, PL);
            end
            if (state == ST_FLUSH && !seen_flush) begin
                seen_flush = 1;
                chk("run_beats", src_acc, NPIX);
            end
            if (pulse_in_run && !pulsed && state == ST_RUN) begin
                pulsed = 1;
                start = 1'b1;
                step();
                start = 1'b0;
                cyc++;
                chk("start_ignored", int'(state == ST_FILL), 0);
            end else if (hold_fl && !held && state == ST_FLUSH && fl_beats >= 2) begin
                held = 1;
                dr_hold_low = 1'b1;
                dp_in_ready = 1'b0;
                fb = fl_beats;
                for (int i = 0; i < 3; i++) begin
                    #1;
                    chk("flush_en_held", flush_en, 1);
                    step();
                    chk("fl_frozen", fl_beats, fb);
                end
                dr_hold_low = 1'b0;
                cyc += 3;
            end else begin
                step();
                cyc++;
            end
        end
        chk("frame_back_idle", int'(state == ST_IDLE), 1);
        chk("outputs_pending", exp_q.size(), 0);
        chk("in_beats", src_acc, NPIX);
        chk("flush_beats", fl_beats, PL);
        chk("done_pulses", done_cnt, 1);
        if (hold_fl) chk("hold_applied", held, 1);
        src_on = 1'b0;
        exp_q.delete();
        dp_q.delete();
        step();
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_state"}, state, ST_IDLE);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_s_ready"}, s_ready, 0);
        chk({tag, "_dp_in_valid"}, dp_in_valid, 0);
        chk({tag, "_flush_en"}, flush_en, 0);
        chk({tag, "_m_valid"}, m_valid, 0);
        chk({tag, "_m_last"}, m_last, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err_last"}, err_last, 0);
    endtask

    task automatic reset_mid_frame();
        int cyc = 0;
        begin_frame(100, 100, 100, NPIX);
        while (src_acc < 7 && cyc < 200) begin
            step();
            cyc++;
        end
        chk("reached_beat7", int'(src_acc >= 7), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("async_rst");
        s_valid = 1'b0; src_on = 1'b0; hs_in = 1'b0; prev_stall = 1'b0; err_exp = 1'b0;
        exp_q.delete();
        dp_q.delete();
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        step();
        step();
        check_idle_outputs("reset");
        rst_n = 1'b1;
        step();

        run_frame(100, 100, 100, NPIX, 0, 0);
        run_frame(100, 50, 100, NPIX, 0, 0);
        run_frame(70, 60, 70, NPIX, 1, 0);
        reset_mid_frame();
        run_frame(100, 100, 100, NPIX, 0, 0);
        run_frame(80, 80, 90, 10, 0, 0);
        chk("err_sticky_after_frame", err_last, LCHK);
        run_frame(100, 70, 100, NPIX, 0, 1);
        for (int r = 0; r < 3; r++) run_frame(60, 50, 60, NPIX, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=%0t expected=finish", $time);
        $fatal(1, "timeout");
    end

endmodule
